// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states; the encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DWAIT = 2'b10
    } pipe_state_t;

    // Architectural zero register: never a real producer, so it never causes a hazard.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Width of the dmem wait counter (saturates at all-ones).
    localparam int WAIT_W = 8;

    // Saturating increment for the dmem wait counter.
    function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] value);
        logic [WAIT_W-1:0] result;
        if (value == {WAIT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count up on inc and stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: boot fill,
// load-use stall, ID redirect flush, dmem wait freeze and watchdog.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int MAX_WAIT    = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             id_redirect_i,
    input  logic             mem_access_i,
    input  logic             dmem_ready_i,
    output logic             dmem_req_o,
    output logic             pc_we_o,
    output logic             pc_sel_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_we_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_we_o,
    output logic             mem_wb_flush_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [3:0]        BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    pipe_state_t       state_r;
    pipe_state_t       state_nxt_s;
    logic [3:0]        boot_cnt_r;
    logic [3:0]        boot_cnt_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              timeout_r;

    logic rs1_hit_s;
    logic rs2_hit_s;
    logic load_use_s;
    logic dmem_stall_s;
    logic eval_hazard_s;
    logic in_pipe_s;
    logic waiting_s;
    logic flush_inc_s;
    logic stall_inc_s;
    logic timeout_set_s;

    // Load-use detection: EX load writing a register the ID instruction reads.
    always_comb begin
        rs1_hit_s    = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit_s    = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
        load_use_s   = ex_mem_read_i && (ex_rd_addr_i != REG_X0) && (rs1_hit_s || rs2_hit_s);
        dmem_stall_s = mem_access_i && !dmem_ready_i;
    end

    // Next-state and stage control decode; enables default on, flushes off.
    always_comb begin
        state_nxt_s    = state_r;
        boot_cnt_nxt_s = boot_cnt_r;
        wait_cnt_nxt_s = wait_cnt_r;
        pc_we_o        = 1'b1;
        pc_sel_o       = 1'b0;
        if_id_we_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_we_o     = 1'b1;
        id_ex_flush_o  = 1'b0;
        ex_mem_we_o    = 1'b1;
        mem_wb_flush_o = 1'b0;
        dmem_req_o     = 1'b0;
        eval_hazard_s  = 1'b0;
        in_pipe_s      = 1'b0;
        waiting_s      = 1'b0;
        flush_inc_s    = 1'b0;

        case (state_r)
            ST_BOOT: begin
                pc_we_o        = 1'b0;
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                mem_wb_flush_o = 1'b1;
                if (boot_cnt_r == BOOT_LAST) begin
                    state_nxt_s    = ST_RUN;
                    boot_cnt_nxt_s = 4'd0;
                end else begin
                    boot_cnt_nxt_s = boot_cnt_r + 4'd1;
                end
            end
            ST_RUN: begin
                in_pipe_s = 1'b1;
                if (dmem_stall_s) begin
                    pc_we_o        = 1'b0;
                    if_id_we_o     = 1'b0;
                    id_ex_we_o     = 1'b0;
                    ex_mem_we_o    = 1'b0;
                    mem_wb_flush_o = 1'b1;
                    dmem_req_o     = 1'b1;
                    state_nxt_s    = ST_DWAIT;
                    wait_cnt_nxt_s = {{(WAIT_W-1){1'b0}}, 1'b1};
                    waiting_s      = 1'b1;
                end else begin
                    dmem_req_o    = mem_access_i;
                    eval_hazard_s = 1'b1;
                end
            end
            ST_DWAIT: begin
                in_pipe_s  = 1'b1;
                dmem_req_o = 1'b1;
                if (!dmem_ready_i) begin
                    // Freeze everything up to MEM so the access stays stable.
                    pc_we_o        = 1'b0;
                    if_id_we_o     = 1'b0;
                    id_ex_we_o     = 1'b0;
                    ex_mem_we_o    = 1'b0;
                    mem_wb_flush_o = 1'b1;
                    wait_cnt_nxt_s = wait_sat_inc(wait_cnt_r);
                    waiting_s      = 1'b1;
                end else begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                    eval_hazard_s  = 1'b1;
                end
            end
            default: begin
                pc_we_o        = 1'b0;
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                mem_wb_flush_o = 1'b1;
                state_nxt_s    = ST_BOOT;
                boot_cnt_nxt_s = 4'd0;
            end
        endcase

        // Load-use outranks redirect: the branch in ID re-resolves next cycle.
        if (eval_hazard_s) begin
            if (load_use_s) begin
                pc_we_o       = 1'b0;
                if_id_we_o    = 1'b0;
                id_ex_flush_o = 1'b1;
            end else if (id_redirect_i) begin
                pc_sel_o      = 1'b1;
                if_id_flush_o = 1'b1;
                flush_inc_s   = 1'b1;
            end else begin
                pc_sel_o = 1'b0;
            end
        end else begin
            pc_sel_o = 1'b0;
        end
    end

    // Watchdog trips on the edge where the wait counter reaches its limit.
    always_comb begin
        timeout_set_s = waiting_s && (wait_cnt_nxt_s >= WAIT_LIMIT);
        stall_inc_s   = in_pipe_s && !pc_we_o;
    end

    // Sequencer state, boot/wait counters and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            boot_cnt_r <= 4'd0;
            wait_cnt_r <= {WAIT_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            boot_cnt_r <= boot_cnt_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (timeout_set_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign timeout_o = timeout_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .cnt   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .cnt   (flush_cnt_o)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB stage registers plus PC).
- Inputs:
  - load-use hazard info from ID and EX.
  - branch/jump redirect resolved in ID.
  - data-memory ready/wait handshake from MEM.
- Outputs: per-stage write-enable/flush controls and the PC update/select controls.
- Also owns the post-reset pipeline fill, a wait-timeout watchdog and saturating performance counters.

Parameters:
- BOOT_CYCLES, 4, cycles all stages are held flushed after reset release (1..15).
- MAX_WAIT, 64, dmem wait cycles before timeout_o is set (1..255).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1_addr_i  in  5  rs1 of instruction in ID
- id_rs2_addr_i  in  5  rs2 of instruction in ID
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_mem_read_i  in  1  instruction in EX is a load
- ex_rd_addr_i  in  5  destination register of EX instruction
- id_redirect_i  in  1  ID resolved taken branch/jump
- mem_access_i  in  1  MEM instruction performs a load/store
- dmem_ready_i  in  1  data memory completes access this cycle
- dmem_req_o  out  1  access request to data memory
- pc_we_o  out  1  PC register update enable
- pc_sel_o  out  1  1 = take redirect target, 0 = advance_pc
- if_id_we_o  out  1  IF_ID write enable
- if_id_flush_o  out  1  IF_ID load bubble (NOP)
- id_ex_we_o  out  1  ID_EX write enable
- id_ex_flush_o  out  1  ID_EX load bubble
- ex_mem_we_o  out  1  EX_MEM write enable
- mem_wb_flush_o  out  1  MEM_WB load bubble (reg_write=0)
- timeout_o  out  1  sticky dmem watchdog flag
- stall_cnt_o  out  CNT_W  cycles with pc_we_o=0 while in RUN or DWAIT
- flush_cnt_o  out  CNT_W  accepted redirects

Behaviour:
- States: BOOT, RUN, DWAIT. Reset → BOOT, boot_cnt=0, counters=0, timeout_o=0.
- Outputs are combinational from state plus inputs; the state, counters and timeout_o are registered.
- Flush has priority over write-enable in the consuming register. Unlisted outputs are 0, except enables, which default to 1.

BOOT:
- pc_we_o=0, all flush=1, dmem_req_o=0.
- boot_cnt increments each cycle. At boot_cnt==BOOT_CYCLES-1 → RUN.
- Reset asserted mid-operation from any state returns to BOOT immediately.

RUN — priority dmem stall > load-use > redirect:
- dmem stall (mem_access_i & ~dmem_ready_i):
  - pc_we_o, if_id_we_o, id_ex_we_o and ex_mem_we_o are all 0.
  - mem_wb_flush_o=1; dmem_req_o=1; next state DWAIT, wait_cnt=1.
- load-use (ex_mem_read_i & ex_rd_addr_i!=0 & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd))):
  - pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1.
  - Any id_redirect_i this cycle is ignored: pc_sel_o=0, no flush_cnt increment. ID re-evaluates next cycle.
- redirect (id_redirect_i):
  - pc_sel_o=1, pc_we_o=1, if_id_flush_o=1, flush_cnt+1.
- mem_access_i & dmem_ready_i in RUN: single-cycle access; dmem_req_o=1, no stall.

DWAIT:
- Same freeze outputs as the RUN dmem stall, with dmem_req_o held 1.
- MEM-stage address/data must stay stable, which is guaranteed by ex_mem_we_o=0.
- ready=0: wait_cnt increments, saturating at 255.
- wait_cnt reaching MAX_WAIT sets timeout_o=1. It clears only on reset, and the wait continues.
- ready=1: this cycle is the completion cycle.
  - mem_wb_flush_o=0, all enables=1, dmem_req_o=1, next state RUN.
  - Load-use and redirect are evaluated as in RUN in this same cycle.

Counters:
- stall_cnt_o increments when pc_we_o=0 in RUN or DWAIT.
- Both counters saturate at all-ones and do not wrap.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state encoding (BOOT=2'b00, RUN=2'b01, DWAIT=2'b10) and the x0 register-address constant.
- Sub-module sat_counter (parameter W; inc input; async active-low reset) is instantiated for stall_cnt and flush_cnt.
- Hazard compare logic stays inline.

Test Plan:
- Reset release, BOOT_CYCLES=4 → flushes=1 and pc_we_o=0 for exactly 4 cycles; pc_we_o=1 on cycle 5; counters remain 0.
- EX load rd=5, ID rs2=5 used → one cycle: pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1, stall_cnt=1. Same with rd=0 → no stall.
- Load-use plus id_redirect_i in same cycle → pc_sel_o=0, flush_cnt unchanged. Next cycle (hazard gone) with redirect → pc_sel_o=1, if_id_flush_o=1, flush_cnt=1.
- mem_access_i=1, dmem_ready_i low for 3 cycles, then high → 3 freeze cycles with mem_wb_flush_o=1 and dmem_req_o=1; resume on the 4th cycle; stall_cnt=3.
- MAX_WAIT=4, ready held low for 10 cycles → timeout_o rises in the 4th wait cycle and stays 1 after ready; reset clears it.
- Assert rst_n=0 mid-DWAIT → outputs immediately take BOOT values asynchronously; counters read 0.
